mult_div_unit: RTL and testbench

Iterative multiply/divide engine with an integrated Lo/Hi register pair. It sits directly downstream of the control unit and consumes its md_is_mult, md_is_unsigned, lhr_wen, lhr_ren and lhr_is_hi outputs. It computes MULT/MULTU/DIV/DIVU over WIDTH cycles and commits {Hi,Lo}. It serves MFHI/MFLO reads and raises a stall while a result is pending.

---
 rtl/mult_div_unit.sv | 161 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide engine with an integrated Hi/Lo register pair.
// A start in IDLE latches operand magnitudes and result signs. CALC then runs
// WIDTH shift-add (multiply) or restoring (divide) iterations. FIX applies the
// sign corrections and the divide-by-zero override before committing {Hi,Lo}.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             lhr_wen,
   input  logic             md_is_mult,
   input  logic             md_is_unsigned,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             lhr_ren,
   input  logic             lhr_is_hi,
   output logic [WIDTH-1:0] rdata,
   output logic             busy,
   output logic             done,
   output logic             stall
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic               op_mult;
   logic               div_zero;
   logic               neg_q;
   logic               neg_r;
   logic [WIDTH-1:0]   operand;
   logic [WIDTH-1:0]   raw_a;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   hi;
   logic [WIDTH-1:0]   lo;

   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH-1:0]   div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] acc_step;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   fix_hi, fix_lo;

   // Two's-complement negate of a WIDTH-bit magnitude when neg is set
   function automatic logic [WIDTH-1:0] apply_sign_w(input logic [WIDTH-1:0] v,
                                                      input logic neg);
      return neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
   endfunction

   // Two's-complement negate of a 2*WIDTH-bit product when neg is set
   function automatic logic [2*WIDTH-1:0] apply_sign_2w(input logic [2*WIDTH-1:0] v,
                                                         input logic neg);
      return neg ? (~v + {{(2*WIDTH-1){1'b0}}, 1'b1}) : v;
   endfunction

   assign busy  = (state != IDLE);
   assign stall = busy & (lhr_ren | lhr_wen);
   assign rdata = lhr_is_hi ? hi : lo;

   // Operand magnitudes and signs, used only on the start edge
   always_comb begin
      a_neg = ~md_is_unsigned & src_a[WIDTH-1];
      b_neg = ~md_is_unsigned & src_b[WIDTH-1];
      a_mag = apply_sign_w(src_a, a_neg);
      b_mag = apply_sign_w(src_b, b_neg);
   end

   // One iteration: multiply adds then shifts right, divide shifts left then trial-subtracts
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? operand : {WIDTH{1'b0}})};
      div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, operand});
      div_diff  = div_shift[WIDTH-1:0] - operand;
      if (op_mult)
         acc_step = {mul_sum, acc[WIDTH-1:1]};
      else if (div_ge)
         acc_step = {div_diff, acc[WIDTH-2:0], 1'b1};
      else
         acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
   end

   // Final sign correction and divide-by-zero override
   always_comb begin
      prod_fix = apply_sign_2w(acc, neg_q);
      if (op_mult) begin
         fix_hi = prod_fix[2*WIDTH-1:WIDTH];
         fix_lo = prod_fix[WIDTH-1:0];
      end else if (div_zero) begin
         fix_hi = raw_a;
         fix_lo = {WIDTH{1'b1}};
      end else begin
         fix_hi = apply_sign_w(acc[2*WIDTH-1:WIDTH], neg_r);
         fix_lo = apply_sign_w(acc[WIDTH-1:0], neg_q);
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic: start only from IDLE, CALC exits when the last iteration is taken
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (lhr_wen) state_nxt = CALC;
         CALC:    if (cnt == CNT_W'(1)) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: latch on start, iterate in CALC, commit Hi/Lo in FIX, pulse done after
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         op_mult  <= 1'b0;
         div_zero <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         operand  <= '0;
         raw_a    <= '0;
         acc      <= '0;
         hi       <= '0;
         lo       <= '0;
         done     <= 1'b0;
      end else begin
         done <= (state == FIX);
         case (state)
            IDLE: begin
               if (lhr_wen) begin
                  op_mult  <= md_is_mult;
                  div_zero <= ~md_is_mult & (src_b == {WIDTH{1'b0}});
                  neg_q    <= a_neg ^ b_neg;
                  neg_r    <= a_neg;
                  raw_a    <= src_a;
                  operand  <= md_is_mult ? a_mag : b_mag;
                  acc      <= {{WIDTH{1'b0}}, (md_is_mult ? b_mag : a_mag)};
                  cnt      <= CNT_W'(WIDTH);
               end
            end
            CALC: begin
               acc <= acc_step;
               cnt <= cnt - CNT_W'(1);
            end
            FIX: begin
               hi <= fix_hi;
               lo <= fix_lo;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_mult_div_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         lhr_wen = 1'b0;
   logic         md_is_mult = 1'b0;
   logic         md_is_unsigned = 1'b0;
   logic [W-1:0] src_a = '0;
   logic [W-1:0] src_b = '0;
   logic         lhr_ren = 1'b0;
   logic         lhr_is_hi = 1'b0;
   logic [W-1:0] rdata;
   logic         busy, done, stall;

   int n_tests = 0;
   int n_fail  = 0;

   mult_div_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .lhr_wen(lhr_wen), .md_is_mult(md_is_mult),
      .md_is_unsigned(md_is_unsigned), .src_a(src_a), .src_b(src_b),
      .lhr_ren(lhr_ren), .lhr_is_hi(lhr_is_hi), .rdata(rdata),
      .busy(busy), .done(done), .stall(stall)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic on sign- or zero-extended operands
   task automatic ref_model(input bit mult, input bit uns, input logic [W-1:0] a,
                            input logic [W-1:0] b, output logic [W-1:0] hi,
                            output logic [W-1:0] lo);
      logic signed [63:0] sa, sb, p, q, r;
      sa = uns ? {32'b0, a} : {{32{a[31]}}, a};
      sb = uns ? {32'b0, b} : {{32{b[31]}}, b};
      if (mult) begin
         p  = sa * sb;
         hi = p[63:32];
         lo = p[31:0];
      end else if (b == '0) begin
         hi = a;
         lo = '1;
      end else begin
         q  = sa / sb;
         r  = sa % sb;
         hi = r[31:0];
         lo = q[31:0];
      end
   endtask

   task automatic start_op(input string tag, input bit mult, input bit uns,
                           input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      lhr_wen = 1'b1; md_is_mult = mult; md_is_unsigned = uns; src_a = a; src_b = b;
      @(posedge clk); #1;
      lhr_wen = 1'b0;
      src_a = $urandom; src_b = $urandom;
      md_is_mult = 1'($urandom); md_is_unsigned = 1'($urandom);
      check({tag, " busy after start"}, busy, 1);
   endtask

   task automatic wait_done(input string tag);
      int cyc = 0;
      bit seen = 0;
      repeat (W + 10) begin
         @(posedge clk); #1;
         cyc++;
         if (done) begin seen = 1; break; end
      end
      check({tag, " done seen"}, seen, 1);
      if (seen) begin
         check({tag, " latency"}, cyc, W + 1);
         check({tag, " busy with done"}, busy, 0);
         @(posedge clk); #1;
         check({tag, " done single pulse"}, done, 0);
      end
   endtask

   task automatic read_hilo(input string tag, input logic [W-1:0] exp_hi,
                            input logic [W-1:0] exp_lo);
      @(negedge clk);
      lhr_ren = 1'b1; lhr_is_hi = 1'b1; #1;
      check({tag, " hi"}, rdata, exp_hi);
      check({tag, " read stall"}, stall, 0);
      lhr_is_hi = 1'b0; #1;
      check({tag, " lo"}, rdata, exp_lo);
      lhr_ren = 1'b0;
   endtask

   task automatic do_op(input string tag, input bit mult, input bit uns,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
      start_op(tag, mult, uns, a, b);
      wait_done(tag);
      read_hilo(tag, exp_hi, exp_lo);
   endtask

   initial begin
      logic [W-1:0] eh, el, ra, rb;
      bit m, u, seen, stall_ok;
      int cyc;

      // Reset state, with requests asserted to show stall stays low when idle
      lhr_ren = 1'b1; lhr_wen = 1'b1;
      repeat (2) @(posedge clk); #1;
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset stall", stall, 0);
      lhr_is_hi = 1'b1; #1;
      check("reset hi", rdata, 0);
      lhr_is_hi = 1'b0; #1;
      check("reset lo", rdata, 0);
      @(negedge clk);
      lhr_wen = 1'b0; lhr_ren = 1'b0; rst = 1'b0;

      do_op("multu max", 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      do_op("mult -7x3", 1, 0, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      do_op("div -7/2", 0, 0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      do_op("divu 0xfffffff9/2", 0, 1, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC);
      do_op("div 7/-2", 0, 0, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
      do_op("div overflow", 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      do_op("divu by zero", 0, 1, 32'd1234, 32'd0, 32'h0000_04D2, 32'hFFFF_FFFF);
      do_op("div -5 by zero", 0, 0, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

      // Read and start in the same idle cycle: old Hi is returned, start is taken
      @(negedge clk);
      lhr_ren = 1'b1; lhr_is_hi = 1'b1;
      lhr_wen = 1'b1; md_is_mult = 1'b1; md_is_unsigned = 1'b1; src_a = 32'd2; src_b = 32'd3;
      #1;
      check("read+start old hi", rdata, 32'hFFFF_FFFB);
      check("read+start stall", stall, 0);
      @(posedge clk); #1;
      lhr_wen = 1'b0; lhr_ren = 1'b0;
      check("read+start busy", busy, 1);
      wait_done("read+start");
      read_hilo("read+start", 32'd0, 32'd6);

      // Read and second start during busy: stall held, second start ignored
      start_op("multu 5x6", 1, 1, 32'd5, 32'd6);
      repeat (2) @(posedge clk);
      @(negedge clk);
      lhr_ren = 1'b1; lhr_wen = 1'b1; md_is_mult = 1'b0; src_a = 32'd100; src_b = 32'd7;
      #1;
      check("busy read stall", stall, 1);
      cyc = 2; seen = 0; stall_ok = 1;
      repeat (W + 10) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 6) lhr_wen = 1'b0;
         if (done) begin seen = 1; break; end
         if (busy && !stall) stall_ok = 0;
      end
      check("busy stall held", stall_ok, 1);
      check("multu 5x6 done seen", seen, 1);
      check("multu 5x6 latency", cyc, W + 1);
      check("stall released at done", stall, 0);
      lhr_ren = 1'b0;
      @(posedge clk); #1;
      check("ignored start not run", busy, 0);
      read_hilo("multu 5x6", 32'd0, 32'd30);

      // Reset in the middle of CALC discards the operation and clears Hi/Lo
      do_op("preset", 0, 1, 32'h0000_0451, 32'h0000_0020, 32'h0000_0011, 32'h0000_0022);
      start_op("divu reset", 0, 1, 32'h1234_5678, 32'd7);
      repeat (9) @(posedge clk);
      #2;
      rst = 1'b1; lhr_is_hi = 1'b1; #1;
      check("mid reset busy", busy, 0);
      check("mid reset done", done, 0);
      check("mid reset hi", rdata, 0);
      lhr_is_hi = 1'b0; #1;
      check("mid reset lo", rdata, 0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (W + 5) begin
         @(posedge clk); #1;
         if (done || busy) seen = 1;
      end
      check("no activity after reset", seen, 0);
      do_op("multu 2x3", 1, 1, 32'd2, 32'd3, 32'd0, 32'd6);

      // Randomized operations against the reference model
      for (int i = 0; i < 30; i++) begin
         m  = 1'($urandom);
         u  = 1'($urandom);
         ra = $urandom;
         case ($urandom_range(0, 4))
            0:       rb = 32'd0;
            1:       rb = 32'hFFFF_FFFF;
            2:       rb = 32'($urandom_range(1, 50));
            3:       begin rb = $urandom; ra = 32'h8000_0000; end
            default: rb = $urandom;
         endcase
         ref_model(m, u, ra, rb, eh, el);
         do_op($sformatf("rand%0d %s%s", i, m ? "mult" : "div", u ? "u" : ""),
               m, u, ra, rb, eh, el);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
